dut_fifo_fwd: RTL and testbench

// - Parametrised successor of the single-register rx->tx forwarder.
// - Forwards DW-bit words from an unthrottled rx_dv/rxd source to a tx_en/txd sink.
// - Sink uses a valid/ready handshake (tx_rdy); a DEPTH-entry FIFO absorbs backpressure.
// - Sits between the rx agent interface and the tx monitor interface of the bench DUT slot.

---
 rtl/dut_fifo_pkg.sv | 7 +
 rtl/dut_fifo_mem.sv | 29 ++
 rtl/dut_fifo_fwd.sv | 66 ++++++
 tb/tb_dut_fifo_fwd.sv | 135 +++++++++++++
 4 files changed

// File: rtl/dut_fifo_pkg.sv
// dut_fifo_pkg: shared defaults and drop counter constants for dut_fifo_fwd
package dut_fifo_pkg;
  localparam int DW_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 8;
  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;
endpackage

// File: rtl/dut_fifo_mem.sv
// dut_fifo_mem: DEPTH x DW flop array with wrapping wr/rd pointers and head output
module dut_fifo_mem
  import dut_fifo_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  assign head = mem[rd_ptr];
endmodule

// File: rtl/dut_fifo_fwd.sv
// dut_fifo_fwd: rx->tx forwarder with a DEPTH-entry FIFO behind a registered output.
// Define FWD_DROP_CNT_EN to add the saturating drop_cnt port.
module dut_fifo_fwd
  import dut_fifo_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DW-1:0]                rxd,
  input  logic                         rx_dv,
  output logic [DW-1:0]                txd,
  output logic                         tx_en,
  input  logic                         tx_rdy,
  output logic [$clog2(DEPTH+2)-1:0]   level,
  output logic                         ovf,
  input  logic                         ovf_clr
`ifdef FWD_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]        drop_cnt
`endif
);
  localparam int LW = $clog2(DEPTH + 2);
  localparam logic [LW-1:0] FULL = LW'(DEPTH + 1);
  logic pop, full, fifo_empty, drop, bypass, push, fpop;
  logic [DW-1:0] head;
  assign pop = tx_en & tx_rdy;
  assign full = level == FULL;
  // level counts OREG too, so the FIFO is empty when level equals tx_en
  assign fifo_empty = level == LW'(tx_en);
  assign drop = rx_dv & full & ~pop;
  assign bypass = rx_dv & fifo_empty & (~tx_en | pop);
  assign push = rx_dv & ~bypass & ~drop;
  assign fpop = pop & ~fifo_empty;
  dut_fifo_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(fpop), .wdata(rxd), .head(head)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      txd <= '0;
      tx_en <= 1'b0;
      level <= '0;
      ovf <= 1'b0;
    end else begin
      if (fpop) begin
        txd <= head;
        tx_en <= 1'b1;
      end else if (bypass) begin
        txd <= rxd;
        tx_en <= 1'b1;
      end else if (pop) tx_en <= 1'b0;
      level <= level + LW'(rx_dv & ~drop) - LW'(pop);
      ovf <= drop | (ovf & ~ovf_clr);
    end
`ifdef FWD_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (drop && drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
`endif
  a_stall: assert property (@(posedge clk) disable iff (!rst_n)
    tx_en && !tx_rdy |=> tx_en && $stable(txd));
  a_level: assert property (@(posedge clk) disable iff (!rst_n) level <= FULL);
  a_nodrop: assert property (@(posedge clk) disable iff (!rst_n)
    rx_dv && level < FULL |=> !$rose(ovf));
endmodule

// File: tb/tb_dut_fifo_fwd.sv
// tb_dut_fifo_fwd: directed bench with a queue model compared every cycle
module tb_dut_fifo_fwd;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH + 2);
  logic clk = 0, rst_n = 0;
  logic [DW-1:0] rxd = '0;
  logic rx_dv = 0, tx_rdy = 0, ovf_clr = 0;
  logic [DW-1:0] txd;
  logic tx_en, ovf;
  logic [LW-1:0] level;
`ifdef FWD_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  int checks = 0, errors = 0;
  logic [DW-1:0] q[$];
  bit m_ovf = 0;
  int m_drop = 0;
  bit m_p, m_d;

  dut_fifo_fwd #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_dv(rx_dv), .txd(txd), .tx_en(tx_en),
    .tx_rdy(tx_rdy), .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef FWD_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  // Model: a queue of held words, capacity DEPTH+1, head is what tx shows
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      m_ovf = 0;
      m_drop = 0;
    end else begin
      m_p = q.size() > 0 && tx_rdy;
      m_d = rx_dv && q.size() == DEPTH + 1 && !m_p;
      if (m_p) void'(q.pop_front());
      if (rx_dv && !m_d) q.push_back(rxd);
      m_ovf = m_d ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      if (m_d && m_drop != 16'hFFFF) m_drop++;
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("m_tx_en", int'(tx_en), int'(q.size() > 0));
      if (q.size() > 0) chk("m_txd", int'(txd), int'(q[0]));
      chk("m_level", int'(level), q.size());
      chk("m_ovf", int'(ovf), int'(m_ovf));
`ifdef FWD_DROP_CNT_EN
      chk("m_drop_cnt", int'(drop_cnt), m_drop);
`endif
    end

  task automatic cyc(input bit dv, input logic [7:0] d, input bit rdy, input bit clr);
    @(negedge clk);
    rx_dv = dv;
    rxd = d;
    tx_rdy = rdy;
    ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_en", int'(tx_en), 0);
    chk("rst_txd", int'(txd), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1;
    // stream with sink always ready
    cyc(1, 8'h11, 1, 0); chk("s_txd0", int'(txd), 'h11); chk("s_en0", int'(tx_en), 1);
    cyc(1, 8'h22, 1, 0); chk("s_txd1", int'(txd), 'h22);
    cyc(1, 8'h33, 1, 0); chk("s_txd2", int'(txd), 'h33); chk("s_lvl", int'(level), 1);
    cyc(0, 8'h00, 1, 0); chk("s_idle", int'(tx_en), 0);
    // stall then release
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hA0 + i), 0, 0);
    chk("st_lvl4", int'(level), 4); chk("st_txd", int'(txd), 'hA0);
    cyc(0, 8'h00, 0, 0); chk("st_hold", int'(txd), 'hA0);
    cyc(0, 8'h00, 1, 0); chk("st_a1", int'(txd), 'hA1); chk("st_lvl3", int'(level), 3);
    cyc(0, 8'h00, 1, 0); chk("st_a2", int'(txd), 'hA2);
    cyc(0, 8'h00, 1, 0); chk("st_a3", int'(txd), 'hA3);
    cyc(0, 8'h00, 1, 0); chk("st_lvl0", int'(level), 0); chk("st_en0", int'(tx_en), 0);
    // fill to full, tenth word dropped
    for (int i = 0; i < 9; i++) cyc(1, 8'(i), 0, 0);
    chk("f_lvl9", int'(level), 9); chk("f_ovf0", int'(ovf), 0);
    cyc(1, 8'h09, 0, 0);
    chk("f_lvl", int'(level), 9); chk("f_ovf1", int'(ovf), 1); chk("f_txd", int'(txd), 0);
`ifdef FWD_DROP_CNT_EN
    chk("f_dcnt", int'(drop_cnt), 1);
`endif
    // full with simultaneous pop and push
    cyc(1, 8'h55, 1, 0); chk("fp_lvl", int'(level), 9); chk("fp_txd", int'(txd), 'h01);
`ifdef FWD_DROP_CNT_EN
    chk("fp_dcnt", int'(drop_cnt), 1);
`endif
    // sticky flag: plain clear, then clear racing a drop
    cyc(0, 8'h00, 0, 1); chk("ov_clr", int'(ovf), 0);
    cyc(1, 8'h66, 0, 1); chk("ov_drop", int'(ovf), 1); chk("ov_lvl", int'(level), 9);
`ifdef FWD_DROP_CNT_EN
    chk("ov_dcnt", int'(drop_cnt), 2);
`endif
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
    chk("d_txd", int'(txd), 'h05); chk("d_lvl5", int'(level), 5);
    // asynchronous reset while busy
    #1;
    rst_n = 0;
    #1;
    chk("ar_en", int'(tx_en), 0); chk("ar_txd", int'(txd), 0);
    chk("ar_lvl", int'(level), 0); chk("ar_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1;
    cyc(1, 8'h77, 1, 0); chk("ar_first", int'(txd), 'h77); chk("ar_en1", int'(tx_en), 1);
    cyc(0, 8'h00, 1, 0); chk("ar_idle", int'(tx_en), 0);
    // mixed traffic, exercises pointer wrap, checked by the model
    for (int i = 0; i < 48; i++) cyc(i % 3 != 0, 8'(i * 7 + 3), i % 4 < 2, i % 11 == 0);
    for (int i = 0; i < 12; i++) cyc(0, 8'h00, 1, 0);
    chk("mx_lvl0", int'(level), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
